// File: rtl/door_keypad_pkg.sv
// Shared key codes and FSM state encoding for the door keypad controller.
package door_keypad_pkg;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;
  localparam logic [3:0] KEY_SET = 4'hC;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StOpen,
    StSet,
    StLocked
  } state_t;

  function automatic logic is_digit(logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_shift4.sv
// Four-digit entry shift register with a saturating digit counter.
module keypad_shift4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  logic [3:0] digit,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [2:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0  <= 4'd0;
      d1  <= 4'd0;
      d2  <= 4'd0;
      d3  <= 4'd0;
      cnt <= 3'd0;
    end else if (clear) begin
      d0  <= 4'd0;
      d1  <= 4'd0;
      d2  <= 4'd0;
      d3  <= 4'd0;
      cnt <= 3'd0;
    end else if (push && (cnt != 3'd4)) begin
      d3  <= d2;
      d2  <= d1;
      d1  <= d0;
      d0  <= digit;
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/door_keypad.sv
// Door keypad controller: entry, compare handshake, open hold, password set and lockout.
module door_keypad
  import door_keypad_pkg::*;
#(
  parameter logic [15:0] DEF_PASS       = 16'h0000,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned OPEN_CYCLES    = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       unlock,
  output logic [3:0] ipass0,
  output logic [3:0] ipass1,
  output logic [3:0] ipass2,
  output logic [3:0] ipass3,
  output logic [3:0] pass0,
  output logic [3:0] pass1,
  output logic [3:0] pass2,
  output logic [3:0] pass3,
  output logic       switch,
  output logic       door_open,
  output logic       deny,
  output logic       locked,
  output logic [2:0] digit_cnt
);

  localparam int unsigned TMAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int unsigned TW = $clog2(TMAX + 1);
  localparam int unsigned FW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] OPEN_T = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] LOCK_T = TW'(LOCKOUT_CYCLES);
  localparam logic [FW-1:0] FMAX   = FW'(MAX_TRIES);

  state_t        state_q;
  logic [FW-1:0] fail_q;
  logic [TW-1:0] timer_q;

  logic          key_digit, key_clr, key_ent, key_set;
  logic          in_entry, entry_full, entry_push, entry_clear, timer_last;
  logic [FW-1:0] fail_next;
  logic          lock_now;

  always_comb begin
    key_digit   = key_valid && is_digit(key_code);
    key_clr     = key_valid && (key_code == KEY_CLR);
    key_ent     = key_valid && (key_code == KEY_ENT);
    key_set     = key_valid && (key_code == KEY_SET);
    in_entry    = (state_q == StIdle) || (state_q == StSet);
    entry_full  = (digit_cnt == 3'd4);
    entry_push  = in_entry && key_digit;
    // A full entry in IDLE must survive into CHECK for the comparator; it is dropped on exit.
    entry_clear = (in_entry && key_clr) ||
                  ((state_q == StIdle) && key_ent && !entry_full) ||
                  ((state_q == StSet) && key_ent) ||
                  (state_q == StCheck);
    timer_last  = (timer_q == TW'(1)) || (timer_q == '0);
    fail_next   = (fail_q == FMAX) ? fail_q : fail_q + FW'(1);
    lock_now    = (fail_next == FMAX);
  end

  keypad_shift4 u_shift (
    .clk   (clk),
    .rst   (rst),
    .clear (entry_clear),
    .push  (entry_push),
    .digit (key_code),
    .d0    (ipass0),
    .d1    (ipass1),
    .d2    (ipass2),
    .d3    (ipass3),
    .cnt   (digit_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      fail_q    <= '0;
      timer_q   <= '0;
      switch    <= 1'b0;
      door_open <= 1'b0;
      deny      <= 1'b0;
      locked    <= 1'b0;
      pass3     <= DEF_PASS[15:12];
      pass2     <= DEF_PASS[11:8];
      pass1     <= DEF_PASS[7:4];
      pass0     <= DEF_PASS[3:0];
    end else begin
      deny <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (key_ent && entry_full) begin
            state_q <= StCheck;
            switch  <= 1'b1;
          end else if (key_ent) begin
            deny   <= 1'b1;
            fail_q <= fail_next;
            if (lock_now) begin
              state_q <= StLocked;
              locked  <= 1'b1;
              timer_q <= LOCK_T;
            end
          end
        end
        StCheck: begin
          switch <= 1'b0;
          if (unlock) begin
            state_q   <= StOpen;
            door_open <= 1'b1;
            fail_q    <= '0;
            timer_q   <= OPEN_T;
          end else begin
            deny   <= 1'b1;
            fail_q <= fail_next;
            if (lock_now) begin
              state_q <= StLocked;
              locked  <= 1'b1;
              timer_q <= LOCK_T;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StOpen: begin
          if (key_set) begin
            state_q   <= StSet;
            door_open <= 1'b0;
            timer_q   <= '0;
          end else if (timer_last) begin
            state_q   <= StIdle;
            door_open <= 1'b0;
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        StSet: begin
          if (key_ent) begin
            if (entry_full) begin
              pass3 <= ipass3;
              pass2 <= ipass2;
              pass1 <= ipass1;
              pass0 <= ipass0;
            end
            state_q <= StIdle;
          end
        end
        StLocked: begin
          if (timer_last) begin
            state_q <= StIdle;
            locked  <= 1'b0;
            fail_q  <= '0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_door_keypad.sv
// Self-checking bench for door_keypad against a transaction-level keypad model.
module tb_door_keypad;

  localparam logic [15:0] DEF = 16'h1473;
  localparam int MAXT  = 3;
  localparam int LOCKC = 20;
  localparam int OPENC = 12;

  localparam int MIdle   = 0;
  localparam int MOpen   = 1;
  localparam int MSet    = 2;
  localparam int MLocked = 3;

  logic       clk = 1'b0;
  logic       rst, key_valid, unlock;
  logic [3:0] key_code;
  logic [3:0] ipass0, ipass1, ipass2, ipass3, pass0, pass1, pass2, pass3;
  logic       switch, door_open, deny, locked;
  logic [2:0] digit_cnt;

  always #5 clk = ~clk;

  // Stand-in for the external door comparator.
  assign unlock = ({ipass3, ipass2, ipass1, ipass0} == {pass3, pass2, pass1, pass0});

  door_keypad #(
    .DEF_PASS       (DEF),
    .MAX_TRIES      (MAXT),
    .LOCKOUT_CYCLES (LOCKC),
    .OPEN_CYCLES    (OPENC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .unlock    (unlock),
    .ipass0    (ipass0),
    .ipass1    (ipass1),
    .ipass2    (ipass2),
    .ipass3    (ipass3),
    .pass0     (pass0),
    .pass1     (pass1),
    .pass2     (pass2),
    .pass3     (pass3),
    .switch    (switch),
    .door_open (door_open),
    .deny      (deny),
    .locked    (locked),
    .digit_cnt (digit_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int          mode;
  logic [3:0]  entry[$];
  logic [15:0] mpass;
  int          fails;

  function automatic logic [15:0] entry_val();
    logic [15:0] v = 16'h0;
    foreach (entry[i]) v = {v[11:0], entry[i]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_entry();
    chk("ipass", {ipass3, ipass2, ipass1, ipass0}, entry_val());
    chk("digit_cnt", 16'(digit_cnt), 16'(entry.size()));
    chk("pass", {pass3, pass2, pass1, pass0}, mpass);
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic fail_attempt();
    chk("deny", 16'(deny), 16'h1);
    chk("open_on_fail", 16'(door_open), 16'h0);
    fails++;
    entry.delete();
    if (fails >= MAXT) begin
      mode = MLocked;
      chk("locked", 16'(locked), 16'h1);
    end else begin
      chk("not_locked", 16'(locked), 16'h0);
    end
    check_entry();
  endtask

  task automatic key(input logic [3:0] k);
    press(k);
    case (mode)
      MIdle, MSet: begin
        if (k <= 4'd9) begin
          if (entry.size() < 4) entry.push_back(k);
        end else if (k == 4'hA) begin
          entry.delete();
        end else if (k == 4'hB && mode == MSet) begin
          if (entry.size() == 4) mpass = entry_val();
          entry.delete();
          mode = MIdle;
        end else if (k == 4'hB) begin
          if (entry.size() == 4) begin
            chk("switch", 16'(switch), 16'h1);
            chk("check_ipass", {ipass3, ipass2, ipass1, ipass0}, entry_val());
            @(posedge clk);
            @(negedge clk);
            chk("switch_off", 16'(switch), 16'h0);
            if (entry_val() == mpass) begin
              chk("open", 16'(door_open), 16'h1);
              chk("deny_on_open", 16'(deny), 16'h0);
              mode  = MOpen;
              fails = 0;
              entry.delete();
              check_entry();
              return;
            end
          end else begin
            chk("switch_short", 16'(switch), 16'h0);
          end
          fail_attempt();
          return;
        end
      end
      MOpen: begin
        if (k == 4'hC) begin
          mode = MSet;
          chk("open_to_set", 16'(door_open), 16'h0);
        end else begin
          chk("open_hold", 16'(door_open), 16'h1);
        end
      end
      default: ;
    endcase
    chk("deny_quiet", 16'(deny), 16'h0);
    check_entry();
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) key(code[i*4 +: 4]);
    key(4'hB);
  endtask

  task automatic wait_open();
    int cnt = 0;
    while (door_open && cnt < 4 * OPENC) begin
      cnt++;
      @(negedge clk);
    end
    chk("open_cycles", 16'(cnt), 16'(OPENC));
    mode = MIdle;
    chk("locked_after_open", 16'(locked), 16'h0);
    check_entry();
  endtask

  task automatic wait_lock();
    int cnt = 0;
    while (locked && cnt < 4 * LOCKC) begin
      cnt++;
      key_valid = 1'($urandom_range(0, 1));
      key_code  = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("lock_cycles", 16'(cnt), 16'(LOCKC));
    mode  = MIdle;
    fails = 0;
    chk("deny_after_lock", 16'(deny), 16'h0);
    check_entry();
  endtask

  task automatic model_reset();
    mode  = MIdle;
    fails = 0;
    mpass = DEF;
    entry.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] k;
    int         n;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_switch", 16'(switch), 16'h0);
    chk("rst_open", 16'(door_open), 16'h0);
    chk("rst_deny", 16'(deny), 16'h0);
    chk("rst_locked", 16'(locked), 16'h0);
    check_entry();
    rst = 1'b0;
    @(negedge clk);

    // Wrong code, then the right one with a full open hold.
    enter_code(16'h1562);
    enter_code(16'h1473);
    wait_open();

    // Three failures, one with a short entry, lead to lockout.
    enter_code(16'h1111);
    key(4'h2);
    key(4'hB);
    enter_code(16'h0000);
    wait_lock();

    // Password change while open, then old code denies and new code opens.
    enter_code(16'h1473);
    key(4'h5);
    key(4'hC);
    enter_code(16'h9876);
    enter_code(16'h1473);
    enter_code(16'h9876);
    wait_open();

    // Overflow of the entry register and clear.
    for (int i = 1; i <= 5; i++) key(4'(i));
    key(4'hD);
    key(4'hC);
    key(4'hA);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        enter_code(mpass);
      end else begin
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++) begin
          if ($urandom_range(0, 9) < 7) k = 4'($urandom_range(0, 9));
          else if ($urandom_range(0, 4) == 0) k = 4'hA;
          else k = 4'($urandom_range(12, 15));
          key(k);
        end
        key(4'hB);
      end
      if (mode == MOpen) begin
        if ($urandom_range(0, 1) == 0) begin
          wait_open();
        end else begin
          key(4'hC);
          n = $urandom_range(3, 5);
          for (int j = 0; j < n; j++) key(4'($urandom_range(0, 9)));
          key(4'hB);
        end
      end
      if (mode == MLocked) wait_lock();
    end

    // Asynchronous reset during OPEN.
    enter_code(mpass);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_open", 16'(door_open), 16'h0);
    check_entry();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset during SET discards the new entry.
    enter_code(DEF);
    key(4'hC);
    for (int i = 5; i <= 8; i++) key(4'(i));
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_entry();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    enter_code(DEF);
    wait_open();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
